regfile_mp: RTL

- Parametrised multi-port register file with an integrated scoreboard; successor to the 2R/1W regfile.
- Sits in the ID stage. Decode reads operands and marks destination registers busy at issue; WB-side ports write results and clear busy.
- Adds N write ports with fixed priority, N read ports, per-register busy tracking, a flush, and a registered busy count.

---
 rtl/regfile_mp_pkg.sv | 10 +
 rtl/regfile_mp_scoreboard.sv | 41 ++++
 rtl/regfile_mp.sv | 62 ++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and default widths for the multi-port register file
package regfile_mp_pkg;
  localparam int RegNumLog2 = 5;
  localparam int RegNum = 1 << RegNumLog2;
  localparam int DefDataW = 32;
  localparam int DefAddrW = RegNumLog2;
  localparam logic [DefDataW-1:0] ZeroWord = '0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable = 1'b1;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: per-register busy bits with flush/write-clear/issue priority and registered busy count
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DefAddrW,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [2**ADDR_W-1:0]     busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int Depth = 2**ADDR_W;
  logic [Depth-1:0] busy_nxt;
  logic [ADDR_W:0] cnt_nxt;
  // Issue is applied after write-clears so a same-cycle new producer keeps the register busy
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] == WriteEnable && wr_addr[k*ADDR_W +: ADDR_W] != '0)
        busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    if (flush) busy_nxt = '0;
    else if (iss_en && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    cnt_nxt = '0;
    for (int j = 1; j < Depth; j++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[j]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N-read/N-write register file with scoreboard; same-cycle write bypass under REGFILE_MP_BYPASS_EN
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DefDataW,
  parameter int ADDR_W = DefAddrW,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int Depth = 2**ADDR_W;
  logic [DATA_W-1:0] regs [Depth];
  logic [Depth-1:0] busy;
  regfile_mp_scoreboard #(.ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy(busy), .busy_cnt(busy_cnt)
  );
  // Later ports overwrite earlier ones in the loop, giving higher index priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < Depth; j++) regs[j] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (wr_en[k] == WriteEnable && wr_addr[k*ADDR_W +: ADDR_W] != '0)
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic b;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      d = regs[a];
      b = busy[a];
`ifdef REGFILE_MP_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++)
        if (wr_en[k] == WriteEnable && a != '0 && wr_addr[k*ADDR_W +: ADDR_W] == a) begin
          d = wr_data[k*DATA_W +: DATA_W];
          b = 1'b0;
        end
`else
`endif
    end
    assign rd_data[i*DATA_W +: DATA_W] = (rst && rd_en[i] == ReadEnable) ? d : DATA_W'(ZeroWord);
    assign rd_busy[i] = rst && rd_en[i] == ReadEnable && b;
  end
endmodule
